// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS definitions: width, taps, checker states, LFSR step
//
// Purpose: definitions shared by the 32-bit LFSR pattern generator and by
// prbs_checker, so that both sides step the sequence the same way.
// Contents:
//   LFSR_W          sequence word width
//   TAP_A..TAP_D    feedback taps (31, 21, 1, 0)
//   state_t         checker states SEEK, VERIFY, LOCKED
//   lfsr_next()     one sequence step, including the all-zero escape
package prbs_pkg;

  localparam int LFSR_W = 32;

  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // All-zero is the LFSR's lock-up state, so it steps to all-ones instead.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] w);
    if (w == '0) begin
      return '1;
    end
    return {w[LFSR_W-2:0], w[TAP_A] ^ w[TAP_B] ^ w[TAP_C] ^ w[TAP_D]};
  endfunction

endpackage

// File: rtl/popcount32.sv
// rtl/popcount32.sv - 32-bit population count for bit-error accounting
//
// Purpose: counts the set bits of a 32-bit word (combinational).
// Built only with PRBS_CHECKER_BITERR_EN defined; the default build has no
// popcount logic at all, so the module itself is absent there.
// Ports:
//   data   in  32  word to count
//   count  out 6   number of ones in data (0..32)
`ifdef PRBS_CHECKER_BITERR_EN
module popcount32 (
  input  logic [31:0] data,
  output logic [5:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++) begin
      count = count + {5'd0, data[i]};
    end
  end

endmodule
`endif

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising 32-bit PRBS word checker
//
// Purpose: receives the LFSR generator's word stream, seeds itself from the
// stream, declares lock after LOCK_COUNT correct predictions and then
// free-runs, flagging and counting every mispredicted word. UNLOCK_COUNT
// consecutive bad words drop lock and restart the search.
// Optional feature macro: PRBS_CHECKER_BITERR_EN - when defined each error
// adds the number of differing bits (1..32) instead of 1.
// Parameters:
//   LOCK_COUNT    consecutive good predictions needed to lock (>=1)
//   UNLOCK_COUNT  consecutive bad words in LOCKED that drop lock (>=1)
//   ERR_W         error counter width
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      asynchronous active-high reset
//   in_valid   in  1      in_data carries a sequence word this cycle
//   in_data    in  32     received generator word
//   clear_err  in  1      synchronous clear of err_count (wins over increment)
//   locked     out 1      high while locked
//   err_pulse  out 1      one-cycle flag for a mispredicted word while locked
//   err_count  out ERR_W  saturating error total
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 8,
  parameter int ERR_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              clear_err,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
);

  localparam int MAX_CNT = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  // Headroom so a 32-bit increment on a full counter cannot wrap before the
  // saturation test.
  localparam int SUM_W   = ERR_W + 7;

  state_t             state;
  logic [LFSR_W-1:0]  exp_word;
  logic [CNT_W-1:0]   cnt;

  logic               match;
  logic [CNT_W-1:0]   cnt_inc;
  logic [5:0]         err_amount;
  logic [SUM_W-1:0]   err_sum;
  logic [ERR_W-1:0]   err_next;
  logic               count_err;

  assign match   = (in_data == exp_word);
  assign cnt_inc = cnt + CNT_W'(1);

`ifdef PRBS_CHECKER_BITERR_EN
  logic [5:0] bit_errs;

  popcount32 u_popcount (
    .data  (in_data ^ exp_word),
    .count (bit_errs)
  );

  assign err_amount = bit_errs;
`else
  assign err_amount = 6'd1;
`endif

  assign err_sum   = {{(SUM_W-ERR_W){1'b0}}, err_count} + {{(SUM_W-6){1'b0}}, err_amount};
  assign err_next  = (err_sum[SUM_W-1:ERR_W] != '0) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  assign count_err = in_valid && (state == LOCKED) && !match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEEK;
      exp_word  <= '0;
      cnt       <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;

      if (in_valid) begin
        case (state)
          SEEK: begin
            exp_word <= lfsr_next(in_data);
            cnt      <= '0;
            state    <= VERIFY;
          end

          // Reseed from every received word so a single bad word during
          // acquisition only restarts the run instead of trapping us.
          VERIFY: begin
            exp_word <= lfsr_next(in_data);
            if (match) begin
              if (cnt_inc == CNT_W'(LOCK_COUNT)) begin
                state  <= LOCKED;
                cnt    <= '0;
                locked <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt <= '0;
            end
          end

          // Free-run from our own prediction so a corrupted word cannot
          // poison the following ones.
          LOCKED: begin
            exp_word <= lfsr_next(exp_word);
            if (match) begin
              cnt <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (cnt_inc == CNT_W'(UNLOCK_COUNT)) begin
                state  <= SEEK;
                cnt    <= '0;
                locked <= 1'b0;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end

          default: begin
            state  <= SEEK;
            cnt    <= '0;
            locked <= 1'b0;
          end
        endcase
      end

      if (clear_err) begin
        err_count <= '0;
      end else if (count_err) begin
        err_count <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - self-checking bench for prbs_checker
module tb_prbs_checker;

  localparam int LOCK_COUNT   = 4;
  localparam int UNLOCK_COUNT = 8;

  localparam int M_SEARCH = 0;
  localparam int M_TRAIN  = 1;
  localparam int M_TRACK  = 2;

`ifdef PRBS_CHECKER_BITERR_EN
  localparam logic [31:0] SINGLE_MASK = 32'h0000_0007;
  localparam int          SINGLE_EXP  = 3;
`else
  localparam logic [31:0] SINGLE_MASK = 32'h0000_0001;
  localparam int          SINGLE_EXP  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        clear_err;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        s_locked;
  logic        s_err_pulse;
  logic [3:0]  s_err_count;

  int errors = 0;
  int checks = 0;

  int          m_mode;
  logic [31:0] m_pred;
  int          m_run;
  logic        m_locked;
  logic        m_pulse;
  int          m_err;
  int          m_err_s;
  logic [31:0] gen_w;

  always #5 clk = ~clk;

  prbs_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_err(clear_err),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT), .ERR_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear_err(clear_err),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count)
  );

  function automatic logic [31:0] ref_next(input logic [31:0] w);
    if (w == 32'd0) return 32'hFFFF_FFFF;
    return {w[30:0], 1'b0} | {31'd0, ^(w & 32'h8020_0003)};
  endfunction

  function automatic int err_weight(input logic [31:0] diff);
`ifdef PRBS_CHECKER_BITERR_EN
    return $countones(diff);
`else
    return (diff != 32'd0) ? 1 : 0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_SEARCH; m_pred = 32'd0; m_run = 0;
    m_locked = 1'b0; m_pulse = 1'b0; m_err = 0; m_err_s = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic c);
    int w;
    m_pulse = 1'b0;
    if (v) begin
      if (m_mode == M_SEARCH) begin
        m_pred = ref_next(d);
        m_run  = 0;
        m_mode = M_TRAIN;
      end else if (m_mode == M_TRAIN) begin
        if (d == m_pred) begin
          m_run++;
          if (m_run == LOCK_COUNT) begin m_mode = M_TRACK; m_run = 0; end
        end else begin
          m_run = 0;
        end
        m_pred = ref_next(d);
      end else begin
        if (d != m_pred) begin
          m_pulse = 1'b1;
          w = err_weight(d ^ m_pred);
          m_err   = (m_err + w > 65535) ? 65535 : m_err + w;
          m_err_s = (m_err_s + w > 15) ? 15 : m_err_s + w;
          m_run++;
          if (m_run == UNLOCK_COUNT) begin m_mode = M_SEARCH; m_run = 0; end
        end else begin
          m_run = 0;
        end
        m_pred = ref_next(m_pred);
      end
    end
    if (c) begin m_err = 0; m_err_s = 0; end
    m_locked = (m_mode == M_TRACK);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic c);
    in_valid = v; in_data = d; clear_err = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    in_valid = 1'b0; clear_err = 1'b0; in_data = $urandom;
  endtask

  task automatic send_clean();
    drive(1'b1, gen_w, 1'b0);
    gen_w = ref_next(gen_w);
  endtask

  task automatic send_bad(input logic [31:0] mask);
    drive(1'b1, gen_w ^ mask, 1'b0);
    gen_w = ref_next(gen_w);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    checks++; if (s_err_count !== 4'd0) begin errors++; $display("FAIL reset_s_err_count: got %0d want 0", s_err_count); end
    rst = 1'b0;
  endtask

  task automatic test_lock_clean();
    gen_w = 32'hFFFF_FFFF;
    for (int i = 1; i <= 5; i++) begin
      send_clean();
      checks++; if (locked !== (i == 5)) begin errors++; $display("FAIL lock_word%0d: got %b want %b", i, locked, (i == 5)); end
    end
    for (int i = 0; i < 995; i++) begin
      send_clean();
      checks++; if (locked !== 1'b1 || err_pulse !== 1'b0) begin
        errors++; $display("FAIL clean_run%0d: locked=%b err_pulse=%b want 1/0", i, locked, err_pulse);
      end
    end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_err_count: got %0d want 0", err_count); end
  endtask

  task automatic test_single_error();
    drive(1'b0, 32'd0, 1'b1);
    send_bad(SINGLE_MASK);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b want 1", err_pulse); end
    checks++; if (err_count !== 16'(SINGLE_EXP)) begin errors++; $display("FAIL single_count: got %0d want %0d", err_count, SINGLE_EXP); end
    for (int i = 0; i < 5; i++) begin
      send_clean();
      checks++; if (err_pulse !== 1'b0 || locked !== 1'b1 || err_count !== 16'(SINGLE_EXP)) begin
        errors++; $display("FAIL single_after%0d: pulse=%b locked=%b count=%0d want 0/1/%0d", i, err_pulse, locked, err_count, SINGLE_EXP);
      end
    end
  endtask

  task automatic test_unlock();
    drive(1'b0, 32'd0, 1'b1);
    for (int i = 1; i <= UNLOCK_COUNT; i++) begin
      drive(1'b1, 32'h1234_5678, 1'b0);
      gen_w = ref_next(gen_w);
      checks++; if (locked !== (i < UNLOCK_COUNT) || err_pulse !== 1'b1 || err_count !== 16'(m_err)) begin
        errors++; $display("FAIL unlock_word%0d: locked=%b pulse=%b count=%0d want %b/1/%0d", i, locked, err_pulse, err_count, (i < UNLOCK_COUNT), m_err);
      end
    end
`ifndef PRBS_CHECKER_BITERR_EN
    checks++; if (err_count !== 16'd8) begin errors++; $display("FAIL unlock_total: got %0d want 8", err_count); end
`endif
    for (int i = 1; i <= 5; i++) begin
      send_clean();
      checks++; if (locked !== (i == 5)) begin errors++; $display("FAIL relock_word%0d: got %b want %b", i, locked, (i == 5)); end
    end
  endtask

  task automatic test_zero_escape();
    pulse_reset();
    gen_w = 32'd0;
    for (int i = 1; i <= 5; i++) begin
      send_clean();
      checks++; if (locked !== (i == 5)) begin errors++; $display("FAIL zero_word%0d: got %b want %b", i, locked, (i == 5)); end
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send_bad(32'd1 << $urandom_range(31, 0));
      send_clean();
    end
    checks++; if (s_err_count !== 4'd15) begin errors++; $display("FAIL sat_small: got %0d want 15", s_err_count); end
    checks++; if (err_count !== 16'd20) begin errors++; $display("FAIL sat_wide: got %0d want 20", err_count); end
    checks++; if (locked !== 1'b1 || s_locked !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b/%b want 1/1", locked, s_locked); end
    drive(1'b1, gen_w ^ 32'h0000_0100, 1'b1);
    gen_w = ref_next(gen_w);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clear_pulse: got %b want 1", err_pulse); end
    checks++; if (err_count !== 16'd0 || s_err_count !== 4'd0) begin
      errors++; $display("FAIL clear_same_cycle: got %0d/%0d want 0/0", err_count, s_err_count);
    end
  endtask

  task automatic test_random_gaps();
    int burst;
    logic v, c;
    logic [31:0] d, mask;
    pulse_reset();
    gen_w = $urandom;
    burst = 0;
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(3, 0) != 0);
      c = ($urandom_range(199, 0) == 0);
      d = $urandom;
      if (v) begin
        if (burst == 0 && $urandom_range(149, 0) == 0) burst = UNLOCK_COUNT + 1;
        mask = 32'd0;
        if (burst > 0) begin
          mask = $urandom | 32'd1;
          burst--;
        end else if ($urandom_range(19, 0) == 0) begin
          mask = 32'd1 << $urandom_range(31, 0);
        end
        d = gen_w ^ mask;
        gen_w = ref_next(gen_w);
      end
      drive(v, d, c);
      checks++; if (locked !== m_locked || err_pulse !== m_pulse || err_count !== 16'(m_err) ||
                    s_locked !== m_locked || s_err_count !== 4'(m_err_s)) begin
        errors++;
        $display("FAIL gaps_cycle%0d: locked=%b pulse=%b count=%0d s_count=%0d want %b/%b/%0d/%0d",
                 i, locked, err_pulse, err_count, s_err_count, m_locked, m_pulse, m_err, m_err_s);
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    pulse_reset();
    gen_w = 32'hCAFE_0001;
    repeat (5) send_clean();
    send_bad(32'h0000_0010);
    checks++; if (locked !== 1'b1 || err_count === 16'd0) begin
      errors++; $display("FAIL midlock_pre: locked=%b count=%0d want 1/nonzero", locked, err_count);
    end
    rst = 1'b1;
    #1;
    checks++; if (locked !== 1'b0 || err_count !== 16'd0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL midlock_async: locked=%b count=%0d pulse=%b want 0/0/0", locked, err_count, err_pulse);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 5; i++) begin
      send_clean();
      checks++; if (locked !== (i == 5)) begin errors++; $display("FAIL midlock_relock%0d: got %b want %b", i, locked, (i == 5)); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lock_clean();
    test_single_error();
    test_unlock();
    test_zero_escape();
    test_saturation();
    test_random_gaps();
    test_reset_mid_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receive-side companion to the 32-bit LFSR pattern generator. It consumes the generator's 32-bit output word stream, self-synchronises to the sequence, and reports lock status and a saturating error count. It sits at the far end of a link or loopback path in led-matrix and pattern test builds, where it proves data integrity.

## Interface

Parameters:
- LOCK_COUNT, 4: consecutive correct predictions required to declare lock (≥1).
- UNLOCK_COUNT, 8: consecutive mispredicted words in LOCKED that force loss of lock (≥1).
- ERR_W, 16: error counter width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is a sequence word this cycle.
- in_data  in  32  received generator word.
- clear_err  in  1  synchronous clear of err_count.
- locked  out  1  registered; high while in LOCKED.
- err_pulse  out  1  one-cycle flag for a mispredicted word in LOCKED.
- err_count  out  ERR_W  saturating error total.

## Operation

- Sequence model, next(w): if w == 0, next = 0xFFFFFFFF; else next = {w[30:0], w[31]^w[21]^w[1]^w[0]}.
- Internal expected word exp[31:0] and a shared run counter cnt.
- States:
  - SEEK: on in_valid, exp <= next(in_data), cnt <= 0, go VERIFY.
  - VERIFY: on in_valid, exp <= next(in_data). On match, cnt++ and go LOCKED when cnt+1 == LOCK_COUNT. On mismatch, cnt <= 0 and stay in VERIFY (reseeded). No errors are counted.
  - LOCKED: on in_valid, exp <= next(exp). The checker free-runs and does not reseed, so one corrupted word gives exactly one error. On match, cnt <= 0. On mismatch, err_pulse is set, err_count increments, and cnt++. When cnt+1 == UNLOCK_COUNT, go SEEK.
- Cycles with in_valid low change nothing; err_pulse is 0 on those cycles.
- err_count saturates at 2^ERR_W−1.
- clear_err has priority over a same-cycle increment: the result is 0.
- Reset values: state SEEK, exp 0, cnt 0, locked 0, err_pulse 0, err_count 0. Reset asserted mid-lock clears locked immediately (asynchronously).

## Timing

- Latency: 1 cycle. locked, err_pulse and err_count reflect the word sampled on the previous edge.
- From reset, with a clean stream: locked rises one cycle after the (1+LOCK_COUNT)th valid word.
- Loss of lock: locked falls one cycle after the UNLOCK_COUNTth consecutive bad word. That word is still counted as an error.
- in_valid may be high every cycle (full throughput), with no gap requirements.

## Configuration

- PRBS_CHECKER_BITERR_EN defined: each error adds popcount(in_data ^ exp), a value from 1 to 32, to err_count, saturating. err_pulse is unchanged.
- Not defined: each error adds 1 (word-error counting). No popcount logic is built.

## Structure

- Shared package prbs_pkg holds:
  - LFSR_W = 32
  - tap constants 31, 21, 1, 0
  - state enum {SEEK, VERIFY, LOCKED}
  - function lfsr_next, including the zero-escape rule. The generator side reuses this function.
- Sub-module popcount32 (32-bit in, 6-bit out, combinational) is instantiated only under PRBS_CHECKER_BITERR_EN.
- All other logic is in prbs_checker.

## Test plan

- Reset, then continuous generator stream 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD, … → locked = 1 one cycle after the 5th valid word; err_count stays 0 over 1000 words.
- Locked, flip bit 0 of one word → a single err_pulse, err_count = 1 (with BITERR_EN and 3 bits flipped → 3). The next words are not flagged and locked stays 1.
- Locked, 8 consecutive words of 0x12345678 → err_count = 8 and locked falls after the 8th. Resuming a clean stream relocks after 5 words.
- VERIFY fed 0x00000000 then 0xFFFFFFFF → counted as a match (zero escape), and lock is reached normally.
- ERR_W = 4 with 20 injected errors → err_count = 15. clear_err asserted in the same cycle as an error → err_count = 0.
- in_valid toggling with idle gaps → identical lock and error results to gapless streaming. rst pulse while locked → locked = 0 and err_count = 0 immediately; relock on the next 5 valid words.
